led_counter_ctrl: RTL and testbench

LED_COUNTER_CTRL -- requirements
Module: led_counter_ctrl

---
 rtl/led_counter_ctrl.sv | 170 +++++++++++++++++
 tb/tb_led_counter_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_counter_ctrl.sv
// LED counter controller: command-driven up/down 8-bit counter with a
// programmable-rate prescaler and IDLE/RUN/APPLY command handshake.
module led_counter_ctrl #(
  parameter int unsigned CLK_FREQ = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic [7:0] leds,
  output logic       running,
  output logic       wrap
);

  localparam logic [31:0] BASE_P = 32'(CLK_FREQ / 2);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_DIR   = 3'd4;
  localparam logic [2:0] OP_RATE  = 3'd5;
  localparam logic [2:0] OP_STEP  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  // Step period for a given rate, never allowed to reach zero.
  function automatic logic [31:0] step_period(input logic [2:0] r);
    logic [31:0] p;
    p = BASE_P >> r;
    if (p == 32'd0) begin
      p = 32'd1;
    end else begin
      p = p;
    end
    return p;
  endfunction

  function automatic logic [7:0] step_value(input logic [7:0] v, input logic down);
    return down ? (v - 8'd1) : (v + 8'd1);
  endfunction

  function automatic logic step_wraps(input logic [7:0] v, input logic down);
    return down ? (v == 8'h00) : (v == 8'hFF);
  endfunction

  state_e      state_q, state_d;
  logic        from_run_q, from_run_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  arg_q, arg_d;
  logic [7:0]  leds_q, leds_d;
  logic [31:0] presc_q, presc_d;
  logic        dir_q, dir_d;
  logic [2:0]  rate_q, rate_d;
  logic        wrap_q, wrap_d;
  logic        running_q, running_d;
  logic        ready_q, ready_d;
  logic        go_run;

  always_comb begin
    state_d    = state_q;
    from_run_d = from_run_q;
    op_d       = op_q;
    arg_d      = arg_q;
    leds_d     = leds_q;
    presc_d    = presc_q;
    dir_d      = dir_q;
    rate_d     = rate_q;
    wrap_d     = 1'b0;
    go_run     = 1'b0;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        // The prescaler only advances in RUN; a tick still lands on an accept edge.
        if (state_q == ST_RUN) begin
          if (presc_q == (step_period(rate_q) - 32'd1)) begin
            presc_d = 32'd0;
            leds_d  = step_value(leds_q, dir_q);
            wrap_d  = step_wraps(leds_q, dir_q);
          end else begin
            presc_d = presc_q + 32'd1;
          end
        end else begin
          presc_d = presc_q;
        end
        if (cmd_valid && ready_q) begin
          op_d       = cmd_op;
          arg_d      = cmd_arg;
          from_run_d = (state_q == ST_RUN);
          state_d    = ST_APPLY;
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        case (op_q)
          OP_NOP:   leds_d = leds_q;
          OP_START: presc_d = 32'd0;
          OP_STOP:  presc_d = presc_q;
          OP_LOAD: begin
            leds_d  = arg_q;
            presc_d = 32'd0;
          end
          OP_DIR:   dir_d = arg_q[0];
          OP_RATE: begin
            rate_d  = arg_q[2:0];
            presc_d = 32'd0;
          end
          OP_STEP: begin
            leds_d = step_value(leds_q, dir_q);
            wrap_d = step_wraps(leds_q, dir_q);
          end
          OP_CLEAR: begin
            leds_d  = 8'h00;
            presc_d = 32'd0;
          end
          default:  leds_d = leds_q;
        endcase
        go_run  = (from_run_q && (op_q != OP_STOP)) || (op_q == OP_START);
        state_d = go_run ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // running stays high through an APPLY that was entered from RUN.
  assign running_d = (state_d == ST_RUN) || ((state_d == ST_APPLY) && from_run_d);
  assign ready_d   = (state_d != ST_APPLY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      from_run_q <= 1'b0;
      op_q       <= 3'd0;
      arg_q      <= 8'h00;
      leds_q     <= 8'h00;
      presc_q    <= 32'd0;
      dir_q      <= 1'b0;
      rate_q     <= 3'd0;
      wrap_q     <= 1'b0;
      running_q  <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      from_run_q <= from_run_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      leds_q     <= leds_d;
      presc_q    <= presc_d;
      dir_q      <= dir_d;
      rate_q     <= rate_d;
      wrap_q     <= wrap_d;
      running_q  <= running_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign leds      = leds_q;
  assign running   = running_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Directed bench for led_counter_ctrl at CLK_FREQ = 16 (base period 8 cycles).
module tb_led_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [7:0] leds;
  logic       running;
  logic       wrap;

  int n_checks = 0;
  int n_pass   = 0;

  led_counter_ctrl #(.CLK_FREQ(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .leds      (leds),
    .running   (running),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] arg;
    logic [7:0] exp_leds;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with cmd_ready high; returns at the negedge after the apply edge.
  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_in_apply", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] e;
    logic       frozen;
    int         acc;

    vecs[0]  = '{3'd3, 8'hA5, 8'hA5, 1'b0};
    vecs[1]  = '{3'd0, 8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{3'd4, 8'h01, 8'hA5, 1'b0};
    vecs[3]  = '{3'd6, 8'h00, 8'hA4, 1'b0};
    vecs[4]  = '{3'd4, 8'h02, 8'hA4, 1'b0};
    vecs[5]  = '{3'd6, 8'h00, 8'hA5, 1'b0};
    vecs[6]  = '{3'd7, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{3'd4, 8'h01, 8'h00, 1'b0};
    vecs[8]  = '{3'd6, 8'h00, 8'hFF, 1'b1};
    vecs[9]  = '{3'd2, 8'h00, 8'hFF, 1'b0};
    vecs[10] = '{3'd4, 8'h00, 8'hFF, 1'b0};
    vecs[11] = '{3'd6, 8'h00, 8'h00, 1'b1};
    vecs[12] = '{3'd3, 8'hFD, 8'hFD, 1'b0};
    vecs[13] = '{3'd5, 8'h00, 8'hFD, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_leds", {24'd0, leds}, 32'h0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Idle-mode command table
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].op, vecs[i].arg);
      chk($sformatf("vec%0d_leds", i), {24'd0, leds}, {24'd0, vecs[i].exp_leds});
      chk($sformatf("vec%0d_wrap", i), {31'd0, wrap}, {31'd0, vecs[i].exp_wrap});
      chk($sformatf("vec%0d_running", i), {31'd0, running}, 32'd0);
      chk($sformatf("vec%0d_ready", i), {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_wrap_drop", i), {31'd0, wrap}, 32'd0);
    end

    // RUN at rate 0: one step every 8 cycles from 0xFD, wrap after edge 24
    send(3'd1, 8'h00);
    chk("start_running", {31'd0, running}, 32'd1);
    chk("start_leds", {24'd0, leds}, 32'hFD);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      e = 8'hFD + 8'(k / 8);
      chk($sformatf("run_k%0d_leds", k), {24'd0, leds}, {24'd0, e});
      chk($sformatf("run_k%0d_wrap", k), {31'd0, wrap}, (k == 24) ? 32'd1 : 32'd0);
    end

    send(3'd2, 8'h00);
    chk("stop_running", {31'd0, running}, 32'd0);
    chk("stop_leds", {24'd0, leds}, 32'h01);
    frozen = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (leds !== 8'h01) frozen = 1'b0;
    end
    chk("stop_frozen_40", {31'd0, frozen}, 32'd1);

    // P = 1: step every RUN cycle, none on the APPLY-ending edge
    send(3'd5, 8'h03);
    send(3'd1, 8'h00);
    e = 8'h01;
    chk("r3_start_leds", {24'd0, leds}, {24'd0, e});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      e = e + 8'd1;
      chk("r3_leds", {24'd0, leds}, {24'd0, e});
    end
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_arg = 8'h07;
    @(negedge clk);
    cmd_valid = 1'b0;
    e = e + 8'd1;
    chk("r7_accept_tick", {24'd0, leds}, {24'd0, e});
    chk("r7_apply_running", {31'd0, running}, 32'd1);
    chk("r7_apply_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("r7_apply_no_step", {24'd0, leds}, {24'd0, e});
    chk("r7_still_running", {31'd0, running}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      e = e + 8'd1;
      chk("r7_leds", {24'd0, leds}, {24'd0, e});
    end
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_arg = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    e = e + 8'd1;
    chk("r7_stop_tick", {24'd0, leds}, {24'd0, e});
    @(negedge clk);
    chk("r7_stop_leds", {24'd0, leds}, {24'd0, e});
    chk("r7_stop_running", {31'd0, running}, 32'd0);

    // cmd_valid held high: STEP on even cycles, LOAD 0 on odd cycles
    acc = 0;
    cmd_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("hold_j%0d_ready", j), {31'd0, cmd_ready}, (j % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("hold_j%0d_leds", j), {24'd0, leds}, {24'd0, 8'(e + 8'(j / 2))});
      if (cmd_ready) acc++;
      cmd_op  = (j % 2 == 0) ? 3'd6 : 3'd3;
      cmd_arg = 8'h00;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_accepts", acc, 32'd5);
    chk("hold_final_leds", {24'd0, leds}, {24'd0, 8'(e + 8'd5)});

    // Reset during APPLY of LOAD 0x3C discards the load
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_arg = 8'h3C;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstapply_leds", {24'd0, leds}, 32'h0);
    chk("rstapply_running", {31'd0, running}, 32'd0);
    chk("rstapply_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("rstapply_no_load", {24'd0, leds}, 32'h0);

    // Reset also restored rate 0 and up-count: first step 8 cycles after START
    send(3'd1, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_k%0d", k), {24'd0, leds}, (k == 8) ? 32'h1 : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
